// File: rtl/lc3_mem_responder.sv
// Closed-loop memory model for the LC3 core: separate instruction and data memories,
// each answered by its own fixed-latency channel, plus a backdoor preload port.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INSTR_LAT = 1,
  parameter int unsigned DATA_LAT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [15:0]       pc,
  output logic [15:0]       Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [15:0]       Data_addr,
  input  logic [15:0]       Data_din,
  output logic [15:0]       Data_dout,
  output logic              complete_data,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] ILAT_M1 = 4'(INSTR_LAT - 1);
  localparam logic [3:0] DLAT_M1 = 4'(DATA_LAT - 1);

  logic [15:0] imem [2**ADDR_W];
  logic [15:0] dmem [2**ADDR_W];

  state_t            ist, ist_nx, dst, dst_nx;
  logic [3:0]        icnt, icnt_nx, dcnt, dcnt_nx;
  logic [ADDR_W-1:0] iaddr, iaddr_use, daddr, daddr_use;
  logic              drd, drd_use;
  logic [15:0]       ddin, ddin_use;
  logic              iaccept, ifire, daccept, dfire, dwrite;
  logic              unused_hi;

  assign unused_hi = ^{pc[15:ADDR_W], Data_addr[15:ADDR_W]};

  // With a latency of 1 the completion happens on the accepting edge, so the
  // "use" signals select the live request instead of the captured copy.
  always_comb begin
    ist_nx    = ist;
    icnt_nx   = icnt;
    iaccept   = 1'b0;
    ifire     = 1'b0;
    iaddr_use = iaddr;
    case (ist)
      S_IDLE: if (instrmem_rd) begin
        iaccept   = 1'b1;
        iaddr_use = pc[ADDR_W-1:0];
        icnt_nx   = ILAT_M1;
        if (INSTR_LAT == 1) begin
          ifire  = 1'b1;
          ist_nx = S_DONE;
        end else begin
          ist_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        icnt_nx = icnt - 4'd1;
        if (icnt == 4'd1) begin
          ifire  = 1'b1;
          ist_nx = S_DONE;
        end
      end
      S_DONE:  ist_nx = S_IDLE;
      default: ist_nx = S_IDLE;
    endcase
  end

  always_comb begin
    dst_nx    = dst;
    dcnt_nx   = dcnt;
    daccept   = 1'b0;
    dfire     = 1'b0;
    daddr_use = daddr;
    drd_use   = drd;
    ddin_use  = ddin;
    case (dst)
      S_IDLE: if (data_req) begin
        daccept   = 1'b1;
        daddr_use = Data_addr[ADDR_W-1:0];
        drd_use   = Data_rd;
        ddin_use  = Data_din;
        dcnt_nx   = DLAT_M1;
        if (DATA_LAT == 1) begin
          dfire  = 1'b1;
          dst_nx = S_DONE;
        end else begin
          dst_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        dcnt_nx = dcnt - 4'd1;
        if (dcnt == 4'd1) begin
          dfire  = 1'b1;
          dst_nx = S_DONE;
        end
      end
      S_DONE:  dst_nx = S_IDLE;
      default: dst_nx = S_IDLE;
    endcase
  end

  assign dwrite = dfire && !drd_use && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ist            <= S_IDLE;
      dst            <= S_IDLE;
      icnt           <= '0;
      dcnt           <= '0;
      iaddr          <= '0;
      daddr          <= '0;
      drd            <= 1'b0;
      ddin           <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
    end else begin
      ist            <= ist_nx;
      dst            <= dst_nx;
      icnt           <= icnt_nx;
      dcnt           <= dcnt_nx;
      complete_instr <= ifire;
      complete_data  <= dfire;
      if (iaccept) iaddr <= iaddr_use;
      if (daccept) begin
        daddr <= daddr_use;
        drd   <= drd_use;
        ddin  <= ddin_use;
      end
      if (ifire) Instr_dout <= imem[iaddr_use];
      if (dfire && drd_use) Data_dout <= dmem[daddr_use];
    end
  end

  // Channel write is issued after the backdoor write so it wins on a collision.
  always_ff @(posedge clock) begin
    if (load_en && !load_sel) imem[load_addr] <= load_data;
    if (load_en && load_sel)  dmem[load_addr] <= load_data;
    if (dwrite)               dmem[daddr_use] <= ddin_use;
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Randomized scoreboard bench for lc3_mem_responder against a word-array memory model.
module tb_lc3_mem_responder;
  localparam int AW = 8;
  localparam int IL = 1;
  localparam int DL = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          instrmem_rd = 1'b0;
  logic [15:0]   pc = '0;
  logic [15:0]   Instr_dout;
  logic          complete_instr;
  logic          data_req = 1'b0;
  logic          Data_rd = 1'b0;
  logic [15:0]   Data_addr = '0;
  logic [15:0]   Data_din = '0;
  logic [15:0]   Data_dout;
  logic          complete_data;
  logic          load_en = 1'b0;
  logic          load_sel = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [15:0] ref_imem [256];
  logic [15:0] ref_dmem [256];
  logic [15:0] ref_dout = '0;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  lc3_mem_responder #(.ADDR_W(AW), .INSTR_LAT(IL), .DATA_LAT(DL)) dut (
    .clock(clock), .reset(reset),
    .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever a completion pulse is seen.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (complete_instr === 1'b1) begin
        if (iq.size() == 0) check("unexpected_complete_instr", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          e = iq.pop_front();
          check("instr_cycle", 32'(cyc), 32'(e.cyc));
          check("instr_dout", {16'h0, Instr_dout}, {16'h0, e.data});
        end
      end
      if (complete_data === 1'b1) begin
        if (dq.size() == 0) check("unexpected_complete_data", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          e = dq.pop_front();
          check("data_cycle", 32'(cyc), 32'(e.cyc));
          check("data_dout", {16'h0, Data_dout}, {16'h0, e.data});
        end
      end
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic bd(input logic sel, input logic [AW-1:0] a, input logic [15:0] d);
    load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
    if (sel) ref_dmem[a] = d; else ref_imem[a] = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic start_fetch(input logic [15:0] a);
    instrmem_rd = 1'b1; pc = a;
    iq.push_back('{cyc + IL, ref_imem[a[AW-1:0]]});
  endtask

  task automatic start_data(input logic rd, input logic [15:0] a, input logic [15:0] d);
    data_req = 1'b1; Data_rd = rd; Data_addr = a; Data_din = d;
    if (rd) ref_dout = ref_dmem[a[AW-1:0]];
    else    ref_dmem[a[AW-1:0]] = d;
    dq.push_back('{cyc + DL, ref_dout});
  endtask

  task automatic drain();
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("FAIL drain_timeout: pending %0d/%0d required 0/0", iq.size(), dq.size());
      iq.delete();
      dq.delete();
    end
    @(negedge clock);
  endtask

  task automatic fetch(input logic [15:0] a, input int hold);
    start_fetch(a);
    repeat (hold) begin
      @(negedge clock);
      pc = 16'($urandom);
    end
    instrmem_rd = 1'b0;
    drain();
  endtask

  task automatic data_op(input logic rd, input logic [15:0] a, input logic [15:0] d, input int hold);
    start_data(rd, a, d);
    repeat (hold) begin
      @(negedge clock);
      Data_addr = 16'($urandom); Data_din = 16'($urandom); Data_rd = 1'($urandom);
    end
    data_req = 1'b0;
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_instr_dout", {16'h0, Instr_dout}, 32'h0);
    check("reset_data_dout", {16'h0, Data_dout}, 32'h0);
    check("reset_complete_instr", {31'h0, complete_instr}, 32'h0);
    check("reset_complete_data", {31'h0, complete_data}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 256; i++) begin
      bd(1'b0, AW'(i), 16'($urandom));
      bd(1'b1, AW'(i), 16'($urandom));
    end

    // Held fetch request: one completion every IL+1 cycles.
    bd(1'b0, 8'h05, 16'h1234);
    instrmem_rd = 1'b1; pc = 16'h0005;
    for (int j = 0; j < 4; j++) iq.push_back('{cyc + IL + j * (IL + 1), 16'h1234});
    repeat (3 * (IL + 1) + 1) @(negedge clock);
    instrmem_rd = 1'b0;
    drain();

    data_op(1'b0, 16'h0010, 16'hBEEF, 1);
    data_op(1'b1, 16'h0010, 16'h0000, 1);
    data_op(1'b0, 16'h0110, 16'hA5A5, 1);
    data_op(1'b1, 16'h0010, 16'h0000, 1);

    // Data issued one cycle ahead so both channels complete together.
    start_data(1'b1, 16'h0003, 16'h0);
    @(negedge clock);
    data_req = 1'b0;
    start_fetch(16'h0002);
    @(negedge clock);
    instrmem_rd = 1'b0;
    drain();

    // Reset during the wait of a write aborts it.
    bd(1'b1, 8'h20, 16'h1111);
    data_op(1'b1, 16'h0020, 16'h0, 1);
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0020; Data_din = 16'hDEAD;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_data_dout", {16'h0, Data_dout}, 32'h0);
    check("async_reset_instr_dout", {16'h0, Instr_dout}, 32'h0);
    check("async_reset_complete_data", {31'h0, complete_data}, 32'h0);
    data_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    ref_dout = '0;
    repeat (4) @(negedge clock);
    data_op(1'b1, 16'h0020, 16'h0, 1);

    // Channel write beats a same-edge backdoor write to the same word.
    start_data(1'b0, 16'h0030, 16'h2222);
    @(negedge clock);
    data_req = 1'b0;
    load_en = 1'b1; load_sel = 1'b1; load_addr = 8'h30; load_data = 16'h3333;
    @(negedge clock);
    load_en = 1'b0;
    drain();
    data_op(1'b1, 16'h0030, 16'h0, 1);

    // Reads completing on a backdoor write edge return the old word.
    start_data(1'b1, 16'h0031, 16'h0);
    @(negedge clock);
    data_req = 1'b0;
    load_en = 1'b1; load_sel = 1'b1; load_addr = 8'h31; load_data = 16'h4444;
    @(negedge clock);
    load_en = 1'b0;
    ref_dmem[8'h31] = 16'h4444;
    drain();
    data_op(1'b1, 16'h0031, 16'h0, 1);

    start_fetch(16'h0040);
    load_en = 1'b1; load_sel = 1'b0; load_addr = 8'h40; load_data = 16'h5555;
    @(negedge clock);
    instrmem_rd = 1'b0;
    load_en = 1'b0;
    ref_imem[8'h40] = 16'h5555;
    drain();
    fetch(16'h0040, 1);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 4))
        0: bd(1'($urandom), AW'($urandom), 16'($urandom));
        1: fetch(16'($urandom), int'($urandom_range(1, IL + 1)));
        2: data_op(1'b1, 16'($urandom), 16'($urandom), int'($urandom_range(1, DL + 1)));
        3: data_op(1'b0, 16'($urandom), 16'($urandom), int'($urandom_range(1, DL + 1)));
        default: begin
          start_data(1'($urandom), 16'($urandom), 16'($urandom));
          start_fetch(16'($urandom));
          @(negedge clock);
          data_req = 1'b0;
          instrmem_rd = 1'b0;
          drain();
        end
      endcase
    end

    repeat (5) @(negedge clock);
    check("instr_queue_empty", 32'(iq.size()), 32'h0);
    check("data_queue_empty", 32'(dq.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
